// File: rtl/quad_adder_scheduler_if.sv
// Bundle of every signal between the adder-stage scheduler, the layer controller, the accumulators,
// the adder stage and the output buffer.
//   slave  : the scheduler side (quad_adder_scheduler)
//   master : the environment side (controller / accumulators / adder / output buffer)
// Signals:
//   start_i, cfg_groups_i, cfg_pixel_count_i : layer request and its configuration
//   acc_done_i, acc_ack_o                    : accumulator finished / sums captured
//   adders_flag_o, stage_finish_o            : adder mode select and stage strobe
//   out_valid_o, out_ready_i, pixel_idx_o    : result handshake towards the output buffer
//   busy_o, done_o                           : layer status
interface quad_adder_scheduler_if #(
    parameter int unsigned PIXEL_CNT_BIT_WIDTH   = 16,
    parameter int unsigned ADDERS_FLAG_BIT_WIDTH = 2,
    parameter int unsigned GROUPS_BIT_WIDTH      = 3
);
    logic                             start_i;
    logic [GROUPS_BIT_WIDTH-1:0]      cfg_groups_i;
    logic [PIXEL_CNT_BIT_WIDTH-1:0]   cfg_pixel_count_i;
    logic                             acc_done_i;
    logic                             acc_ack_o;
    logic [ADDERS_FLAG_BIT_WIDTH-1:0] adders_flag_o;
    logic                             stage_finish_o;
    logic                             out_valid_o;
    logic                             out_ready_i;
    logic [PIXEL_CNT_BIT_WIDTH-1:0]   pixel_idx_o;
    logic                             busy_o;
    logic                             done_o;

    modport slave (
        input  start_i, cfg_groups_i, cfg_pixel_count_i, acc_done_i, out_ready_i,
        output acc_ack_o, adders_flag_o, stage_finish_o, out_valid_o, pixel_idx_o, busy_o,
               done_o
    );

    modport master (
        output start_i, cfg_groups_i, cfg_pixel_count_i, acc_done_i, out_ready_i,
        input  acc_ack_o, adders_flag_o, stage_finish_o, out_valid_o, pixel_idx_o, busy_o,
               done_o
    );
endinterface

// File: rtl/quad_adder_scheduler.sv
// Scheduler for the four-input accumulator adder stage. Per output pixel it waits for the
// accumulators, fires a one-cycle stage-finish strobe (with the accumulator ack), covers the
// adder's two-cycle pipeline and then presents the result with a valid/ready handshake. The adder
// cannot stall, so the next strobe is only issued after the current result has been consumed.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous reset, active-high
//   bus : quad_adder_scheduler_if.slave (configuration, accumulator, adder and output handshake)
module quad_adder_scheduler #(
    parameter int unsigned PIXEL_CNT_BIT_WIDTH   = 16,
    parameter int unsigned ADDERS_FLAG_BIT_WIDTH = 2,
    parameter int unsigned GROUPS_BIT_WIDTH      = 3
) (
    input logic                   clk,
    input logic                   rst,
    quad_adder_scheduler_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StWaitAcc,
        StFire,
        StPipe,
        StValid,
        StDone
    } state_e;

    state_e                           state_q, state_d;
    logic [PIXEL_CNT_BIT_WIDTH-1:0]   idx_q, idx_d;
    logic [PIXEL_CNT_BIT_WIDTH-1:0]   count_q, count_d;
    logic [ADDERS_FLAG_BIT_WIDTH-1:0] flag_q, flag_d;
    logic                             fire_q;

    logic [GROUPS_BIT_WIDTH-1:0]      groups_clamped;
    logic [ADDERS_FLAG_BIT_WIDTH-1:0] flag_map;
    logic                             last_pixel;

    // Out-of-range group counts saturate: 0 behaves as 1, anything above 4 as 4.
    always_comb begin
        if (bus.cfg_groups_i == '0) begin
            groups_clamped = GROUPS_BIT_WIDTH'(1);
        end else if (bus.cfg_groups_i > GROUPS_BIT_WIDTH'(4)) begin
            groups_clamped = GROUPS_BIT_WIDTH'(4);
        end else begin
            groups_clamped = bus.cfg_groups_i;
        end
    end

    assign flag_map   = ADDERS_FLAG_BIT_WIDTH'(groups_clamped - GROUPS_BIT_WIDTH'(1));
    assign last_pixel = (idx_q == count_q - PIXEL_CNT_BIT_WIDTH'(1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        flag_d  = flag_q;
        case (state_q)
            StIdle: begin
                if (bus.start_i) begin
                    flag_d  = flag_map;
                    count_d = bus.cfg_pixel_count_i;
                    idx_d   = '0;
                    // An empty layer completes without touching the adder.
                    state_d = (bus.cfg_pixel_count_i == '0) ? StDone : StWaitAcc;
                end
            end
            StWaitAcc: begin
                if (bus.acc_done_i) begin
                    state_d = StFire;
                end
            end
            StFire:  state_d = StPipe;
            StPipe:  state_d = StValid;
            StValid: begin
                if (bus.out_ready_i) begin
                    if (last_pixel) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + PIXEL_CNT_BIT_WIDTH'(1);
                        state_d = StWaitAcc;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            count_q <= '0;
            flag_q  <= '0;
            fire_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            flag_q  <= flag_d;
            // Strobe is its own flop so it leaves the block glitch-free.
            fire_q  <= (state_d == StFire);
        end
    end

    assign bus.stage_finish_o = fire_q;
    assign bus.acc_ack_o      = fire_q;
    assign bus.adders_flag_o  = flag_q;
    assign bus.pixel_idx_o    = idx_q;
    assign bus.out_valid_o    = (state_q == StValid);
    assign bus.busy_o         = (state_q != StIdle);
    assign bus.done_o         = (state_q == StDone);

endmodule

// File: tb/tb_quad_adder_scheduler.sv
// Self-checking bench for quad_adder_scheduler: an event/timestamp model of the pixel flow is
// compared against the DUT every cycle, and directed scenarios pin the model with literal values.
module tb_quad_adder_scheduler;

    localparam int PW = 16;
    localparam int FW = 2;
    localparam int GW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    quad_adder_scheduler_if #(
        .PIXEL_CNT_BIT_WIDTH  (PW),
        .ADDERS_FLAG_BIT_WIDTH(FW),
        .GROUPS_BIT_WIDTH     (GW)
    ) bus_if ();

    quad_adder_scheduler #(
        .PIXEL_CNT_BIT_WIDTH  (PW),
        .ADDERS_FLAG_BIT_WIDTH(FW),
        .GROUPS_BIT_WIDTH     (GW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model: layer progress tracked as phases plus strobe timestamps -----------
    typedef enum int {MIdle, MWait, MFlight, MDone} mphase_e;

    mphase_e m_mode    = MIdle;
    int      m_count   = 0;
    int      m_idx     = 0;
    int      m_flag    = 0;
    int      m_fire_at = -100;
    int      cyc       = 0;

    task automatic model_reset();
        m_mode    = MIdle;
        m_count   = 0;
        m_idx     = 0;
        m_flag    = 0;
        m_fire_at = -100;
    endtask

    // Called at each rising edge; cyc then names the period that follows the edge.
    task automatic model_step();
        int p;
        int g;
        p = cyc - 1;
        case (m_mode)
            MIdle: if (bus_if.start_i) begin
                g = int'(bus_if.cfg_groups_i);
                if (g < 1) g = 1;
                if (g > 4) g = 4;
                m_flag  = g - 1;
                m_count = int'(bus_if.cfg_pixel_count_i);
                m_idx   = 0;
                m_mode  = (m_count == 0) ? MDone : MWait;
            end
            MWait: if (bus_if.acc_done_i) begin
                m_mode    = MFlight;
                m_fire_at = cyc;
            end
            MFlight: if (p >= m_fire_at + 2 && bus_if.out_ready_i) begin
                if (m_idx == m_count - 1) begin
                    m_mode = MDone;
                end else begin
                    m_idx++;
                    m_mode = MWait;
                end
            end
            MDone: m_mode = MIdle;
            default: m_mode = MIdle;
        endcase
    endtask

    initial forever begin
        @(posedge rst);
        model_reset();
    end

    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst) model_reset();
        else model_step();
    end

    // ---------------- per-cycle compare and event recording ----------------
    int strobe_q[$];
    int ack_q[$];
    int vrise_q[$];
    int hs_idx_q[$];
    int hs_cyc_q[$];
    int done_q[$];
    bit prev_valid = 1'b0;

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            check("busy",         bus_if.busy_o,         m_mode != MIdle);
            check("done",         bus_if.done_o,         m_mode == MDone);
            check("stage_finish", bus_if.stage_finish_o, m_mode == MFlight && cyc == m_fire_at);
            check("acc_ack",      bus_if.acc_ack_o,      m_mode == MFlight && cyc == m_fire_at);
            check("out_valid",    bus_if.out_valid_o,    m_mode == MFlight && cyc >= m_fire_at + 2);
            check("adders_flag",  bus_if.adders_flag_o,  m_flag);
            check("pixel_idx",    bus_if.pixel_idx_o,    m_idx);
            if (bus_if.stage_finish_o) strobe_q.push_back(cyc);
            if (bus_if.acc_ack_o) ack_q.push_back(cyc);
            if (bus_if.out_valid_o && !prev_valid) vrise_q.push_back(cyc);
            if (bus_if.out_valid_o && bus_if.out_ready_i) begin
                hs_idx_q.push_back(int'(bus_if.pixel_idx_o));
                hs_cyc_q.push_back(cyc);
            end
            if (bus_if.done_o) done_q.push_back(cyc);
            prev_valid = bus_if.out_valid_o;
        end else begin
            prev_valid = 1'b0;
        end
    end

    // ---------------- stimulus helpers (inputs change 1 time unit after the rising edge) -------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        strobe_q.delete();
        ack_q.delete();
        vrise_q.delete();
        hs_idx_q.delete();
        hs_cyc_q.delete();
        done_q.delete();
    endtask

    task automatic do_start(input int g, input int cnt);
        bus_if.start_i           = 1'b1;
        bus_if.cfg_groups_i      = GW'(g);
        bus_if.cfg_pixel_count_i = PW'(cnt);
        step();
        bus_if.start_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (bus_if.done_o) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: done_o not seen within %0d cycles", name, max_cycles);
        end
        step();
    endtask

    initial begin
        bit found;
        int a;
        int s;

        bus_if.start_i           = 1'b0;
        bus_if.cfg_groups_i      = '0;
        bus_if.cfg_pixel_count_i = '0;
        bus_if.acc_done_i        = 1'b0;
        bus_if.out_ready_i       = 1'b0;

        // Reset state
        step();
        step();
        check("rst_busy",   bus_if.busy_o,         0);
        check("rst_done",   bus_if.done_o,         0);
        check("rst_strobe", bus_if.stage_finish_o, 0);
        check("rst_ack",    bus_if.acc_ack_o,      0);
        check("rst_valid",  bus_if.out_valid_o,    0);
        check("rst_flag",   bus_if.adders_flag_o,  0);
        check("rst_idx",    bus_if.pixel_idx_o,    0);
        rst = 1'b0;
        step();

        // Reset while presenting pixel 5
        bus_if.acc_done_i  = 1'b1;
        bus_if.out_ready_i = 1'b1;
        do_start(1, 8);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus_if.out_valid_o && bus_if.pixel_idx_o == PW'(5)) begin
                found = 1'b1;
                break;
            end
            step();
        end
        bus_if.out_ready_i = 1'b0;
        check("a_reach_idx5", found, 1);
        step();
        #1;
        rst = 1'b1;
        #1;
        check("a_async_valid", bus_if.out_valid_o, 0);
        check("a_async_busy",  bus_if.busy_o,      0);
        check("a_async_idx",   bus_if.pixel_idx_o, 0);
        step();
        rst = 1'b0;
        step();
        clear_log();
        bus_if.out_ready_i = 1'b1;
        do_start(2, 1);
        check("a_flag_01", bus_if.adders_flag_o, 1);
        wait_done("a_restart", 40);
        check("a_hs_count", hs_idx_q.size(), 1);
        check("a_no_stale_done", done_q.size(), 1);

        // Four groups, three pixels at full rate
        clear_log();
        do_start(4, 3);
        wait_done("b_run", 60);
        check("b_flag_11", bus_if.adders_flag_o, 3);
        check("b_strobes", strobe_q.size(), 3);
        check("b_hs_count", hs_idx_q.size(), 3);
        if (strobe_q.size() == 3 && hs_idx_q.size() == 3 && done_q.size() == 1) begin
            check("b_gap0", strobe_q[1] - strobe_q[0], 4);
            check("b_gap1", strobe_q[2] - strobe_q[1], 4);
            check("b_idx0", hs_idx_q[0], 0);
            check("b_idx1", hs_idx_q[1], 1);
            check("b_idx2", hs_idx_q[2], 2);
            check("b_done_lat", done_q[0] - hs_cyc_q[2], 1);
        end

        // Latency from acc_done
        clear_log();
        bus_if.acc_done_i = 1'b0;
        do_start(3, 1);
        step();
        step();
        step();
        a = cyc;
        bus_if.acc_done_i = 1'b1;
        wait_done("c_run", 40);
        check("c_flag_10", bus_if.adders_flag_o, 2);
        check("c_count", strobe_q.size() + vrise_q.size() + ack_q.size(), 3);
        if (strobe_q.size() == 1 && vrise_q.size() == 1 && ack_q.size() == 1) begin
            check("c_strobe_lat", strobe_q[0], a + 1);
            check("c_ack_lat",    ack_q[0],    a + 1);
            check("c_valid_lat",  vrise_q[0],  a + 3);
        end

        // Backpressure: seven cycles of ready low, handshake on the eighth
        clear_log();
        bus_if.out_ready_i = 1'b0;
        do_start(2, 2);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus_if.out_valid_o) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("d_reach_valid", found, 1);
        s = strobe_q.size();
        for (int i = 1; i <= 7; i++) begin
            step();
            if (i == 7) bus_if.out_ready_i = 1'b1;
            check("d_hold_valid", bus_if.out_valid_o, 1);
            check("d_hold_idx",   bus_if.pixel_idx_o, 0);
        end
        check("d_no_strobe", strobe_q.size(), s);
        wait_done("d_run", 40);
        check("d_hs_count", hs_idx_q.size(), 2);
        if (hs_idx_q.size() == 2 && vrise_q.size() == 2) begin
            check("d_idx1", hs_idx_q[1], 1);
            check("d_hs_wait", hs_cyc_q[0] - vrise_q[0], 7);
        end

        // Group clamping and empty layers
        clear_log();
        do_start(0, 0);
        check("e_done0",   bus_if.done_o,        1);
        check("e_flag_00", bus_if.adders_flag_o, 0);
        step();
        check("e_idle0", bus_if.busy_o, 0);
        do_start(7, 0);
        check("e_done7",   bus_if.done_o,        1);
        check("e_flag_11", bus_if.adders_flag_o, 3);
        step();
        check("e_no_strobe", strobe_q.size(), 0);
        check("e_no_valid",  vrise_q.size(),  0);

        // start while busy is ignored
        clear_log();
        do_start(4, 3);
        step();
        step();
        bus_if.start_i           = 1'b1;
        bus_if.cfg_groups_i      = GW'(1);
        bus_if.cfg_pixel_count_i = PW'(1);
        step();
        bus_if.start_i = 1'b0;
        check("f_flag_kept", bus_if.adders_flag_o, 3);
        wait_done("f_run", 60);
        check("f_hs_count", hs_idx_q.size(), 3);
        if (hs_idx_q.size() == 3) check("f_last_idx", hs_idx_q[2], 2);
        check("f_flag_end", bus_if.adders_flag_o, 3);
        step();
        check("f_idle", bus_if.busy_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/quad_adder_scheduler.md
Name: quad_adder_scheduler

Overview:
Sequences the four-input accumulator adder stage. For each output pixel it selects how many accumulator groups are summed, fires the one-cycle stage-finish strobe once the accumulators are done, and tracks the adder's two-cycle pipeline. It then presents each result to the output buffer with a valid/ready handshake. The adder cannot stall, so a new strobe is issued only after the previous result has been consumed.

Parameters:
PIXEL_CNT_BIT_WIDTH, 16, width of the pixel counter, cfg_pixel_count_i and pixel_idx_o
ADDERS_FLAG_BIT_WIDTH, 2, width of adders_flag_o
GROUPS_BIT_WIDTH, 3, width of cfg_groups_i

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous reset, active-high
start_i  input  1  one-cycle request to begin a layer; sampled only in IDLE
cfg_groups_i  input  GROUPS_BIT_WIDTH  number of active accumulator groups (1..4); latched on an accepted start
cfg_pixel_count_i  input  PIXEL_CNT_BIT_WIDTH  number of output pixels in the layer; latched on an accepted start
acc_done_i  input  1  accumulators hold a finished pixel sum
acc_ack_o  output  1  one-cycle pulse: sums captured, accumulators may restart
adders_flag_o  output  ADDERS_FLAG_BIT_WIDTH  adder mode select, registered
stage_finish_o  output  1  one-cycle strobe to the adder stage, registered
out_valid_o  output  1  adder result is valid
out_ready_i  input  1  output buffer accepts the result
pixel_idx_o  output  PIXEL_CNT_BIT_WIDTH  index of the pixel being processed or presented
busy_o  output  1  high in every state except IDLE
done_o  output  1  one-cycle pulse after the last pixel is consumed

Behaviour:
- Reset (asynchronous, any state): state = IDLE; all outputs = 0; adders_flag_o = 2'b00; latched configuration = 0.
- Group mapping, applied when start is accepted: adders_flag_o = groups-1, so 1->00, 2->01, 3->10, 4->11. cfg_groups_i = 0 is treated as 1; values above 4 are treated as 4.
- adders_flag_o is constant from an accepted start until the next accepted start. IDLE keeps the last value.
- States: IDLE, WAIT_ACC, FIRE, PIPE, VALID, DONE.
- IDLE:
  - start_i = 1 and count > 0: latch configuration, pixel_idx_o = 0, go to WAIT_ACC.
  - start_i = 1 and count = 0: go to DONE directly; no strobe is issued.
- WAIT_ACC: acc_done_i = 1 -> FIRE. Otherwise stay.
- FIRE (exactly one cycle): stage_finish_o = 1 and acc_ack_o = 1. Go to PIPE.
- PIPE (one cycle): the adder's second stage computes. Go to VALID.
- VALID:
  - out_valid_o = 1; pixel_idx_o is held stable.
  - Handshake occurs when out_valid_o and out_ready_i are both 1 in the same cycle.
  - On handshake with pixel_idx_o = count-1: go to DONE.
  - On any other handshake: increment pixel_idx_o and go to WAIT_ACC.
  - out_ready_i = 0: stay in VALID indefinitely with no new strobe.
- DONE (one cycle): done_o = 1, then go to IDLE. busy_o drops on the cycle IDLE is entered.
- Latency: acc_done_i sampled high at edge E -> stage_finish_o high in cycle E+1 -> out_valid_o high in cycle E+3. The adder output is valid from the cycle after PIPE, which is exactly the VALID cycle.
- Minimum pixel period is 4 cycles (WAIT_ACC, FIRE, PIPE, VALID) when acc_done_i and out_ready_i are held high.
- acc_done_i is ignored outside WAIT_ACC. start_i is ignored while busy_o = 1, and the latched configuration is not disturbed.
- Reset during FIRE/PIPE/VALID: the pending result is discarded. out_valid_o falls immediately (asynchronously) and no done_o pulse is produced.
- The pixel counter never wraps. The maximum count of 2^PIXEL_CNT_BIT_WIDTH-1 completes normally.

Test Plan:
- Reset mid-VALID with pixel_idx_o = 5 -> out_valid_o, busy_o and pixel_idx_o read 0 in the same cycle; next start with cfg_groups_i = 2 proceeds normally with adders_flag_o = 01.
- cfg_groups_i = 4, count = 3, acc_done_i and out_ready_i held high -> adders_flag_o = 11; three stage_finish_o pulses 4 cycles apart; pixel_idx_o presented as 0,1,2; done_o 1 cycle after the third handshake.
- cfg_groups_i = 3, count = 1, acc_done_i raised at cycle 10 -> stage_finish_o at cycle 11, out_valid_o at cycle 13; adders_flag_o = 10; acc_ack_o pulses with stage_finish_o.
- Backpressure: out_ready_i = 0 for 7 cycles in VALID -> out_valid_o held high, pixel_idx_o stable, no stage_finish_o even with acc_done_i high; handshake on the 8th cycle.
- cfg_groups_i = 0 -> adders_flag_o = 00; cfg_groups_i = 7 -> adders_flag_o = 11; start with count = 0 -> done_o the cycle after start, with no stage_finish_o or out_valid_o.
- start_i pulsed with cfg_groups_i = 1 while busy -> ignored; adders_flag_o and the remaining pixel count are unchanged.
